// File: rtl/timebase_event_scheduler_pkg.sv
// Shared types and default widths for the time base / alarm scheduler.
//   slot_state_t : per-slot alarm lifecycle (IDLE -> ARMED -> PENDING -> IN_OUT -> IDLE)
//   *_DEF        : default parameter values used by the interface and top module
package timebase_pkg;

  localparam int          TIME_W_DEF     = 32;
  localparam int          FRAC_W_DEF     = 8;
  localparam int          NUM_SLOTS_DEF  = 4;
  localparam int          SLOT_W_DEF     = 2;
  localparam logic [63:0] STEP_RESET_DEF = 64'h100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2,
    IN_OUT  = 2'd3
  } slot_state_t;

endpackage

// File: rtl/timebase_event_scheduler_if.sv
// Handshake bundle between requesters/consumers and the scheduler.
//   arm_valid/arm_slot/arm_time -> arm_ready : arm one alarm slot
//   evt_valid/evt_slot/evt_time -> evt_ready : expired alarm delivery
// master = requester/consumer side, slave = scheduler side.
interface timebase_event_scheduler_if
  import timebase_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF,
  parameter int SLOT_W = SLOT_W_DEF
);

  logic              arm_valid;
  logic [SLOT_W-1:0] arm_slot;
  logic [TIME_W-1:0] arm_time;
  logic              arm_ready;

  logic              evt_valid;
  logic [SLOT_W-1:0] evt_slot;
  logic [TIME_W-1:0] evt_time;
  logic              evt_ready;

  modport master (
    output arm_valid, arm_slot, arm_time, evt_ready,
    input  arm_ready, evt_valid, evt_slot, evt_time
  );

  modport slave (
    input  arm_valid, arm_slot, arm_time, evt_ready,
    output arm_ready, evt_valid, evt_slot, evt_time
  );

endinterface

// File: rtl/timebase_event_scheduler_rr_arbiter.sv
// Round-robin arbiter over NUM_SLOTS requests.
//   clk, rst : clock, asynchronous active-high reset
//   i_req    : request vector
//   i_en     : grant is taken this cycle; pointer moves to the granted index
//   o_grant  : one-hot grant
//   o_idx    : granted index
//   o_any    : at least one request present
// Search starts at pointer+1, so the last winner has lowest priority.
module rr_arbiter
  import timebase_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SLOT_W    = SLOT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SLOTS-1:0] i_req,
  input  logic                 i_en,
  output logic [NUM_SLOTS-1:0] o_grant,
  output logic [SLOT_W-1:0]    o_idx,
  output logic                 o_any
);

  logic [SLOT_W-1:0] r_ptr;
  logic              w_found;
  logic [SLOT_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int off = 1; off <= NUM_SLOTS; off++) begin
      w_cand = SLOT_W'((int'(r_ptr) + off) % NUM_SLOTS);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
    o_any = w_found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= SLOT_W'(NUM_SLOTS - 1);
    end else if (i_en && o_any) begin
      r_ptr <= o_idx;
    end
  end

endmodule

// File: rtl/timebase_event_scheduler.sv
// Fixed-point time base (ns.frac) advanced by a programmable step per clock,
// plus NUM_SLOTS one-shot alarms sharing one registered event output.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : time base advances by step on each edge when high
//   cfg_step_we  : load cfg_step into the step register (used from next edge)
//   cfg_step     : new step, TIME_W.FRAC_W fixed point
//   now_time     : current time register
//   bus (slave)  : arm handshake in, event handshake out
module timebase_event_scheduler
  import timebase_pkg::*;
#(
  parameter int          TIME_W     = TIME_W_DEF,
  parameter int          FRAC_W     = FRAC_W_DEF,
  parameter int          NUM_SLOTS  = NUM_SLOTS_DEF,
  parameter int          SLOT_W     = SLOT_W_DEF,
  parameter logic [63:0] STEP_RESET = STEP_RESET_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_step_we,
  input  logic [TIME_W+FRAC_W-1:0] cfg_step,
  output logic [TIME_W+FRAC_W-1:0] now_time,
  timebase_event_scheduler_if.slave bus
);

  localparam int STEP_W = TIME_W + FRAC_W;

  // Wrap-aware "now has reached target": the difference is treated as a
  // signed distance, giving a half-range (2^(TIME_W-1) ns) look-back window.
  function automatic logic is_expired(input logic [TIME_W-1:0] now_int,
                                      input logic [TIME_W-1:0] tgt);
    logic signed [TIME_W-1:0] d;
    d = signed'(now_int - tgt);
    return !d[TIME_W-1];
  endfunction

  logic [STEP_W-1:0]    r_now;
  logic [STEP_W-1:0]    r_step;
  slot_state_t          r_state  [NUM_SLOTS];
  logic [TIME_W-1:0]    r_target [NUM_SLOTS];

  logic                 r_evt_vld_p1;
  logic [SLOT_W-1:0]    r_evt_slot_p1;
  logic [TIME_W-1:0]    r_evt_time_p1;

  logic [TIME_W-1:0]    w_now_int;
  logic [NUM_SLOTS-1:0] w_req;
  logic [NUM_SLOTS-1:0] w_grant;
  logic [SLOT_W-1:0]    w_idx;
  logic                 w_any;
  logic                 w_load;
  logic                 w_evt_hs;
  logic                 w_arm_hs;

  assign w_now_int = r_now[STEP_W-1:FRAC_W];
  assign now_time  = r_now;

  // Output register can take a new event when empty or being drained.
  assign w_load   = !r_evt_vld_p1 || bus.evt_ready;
  assign w_evt_hs = r_evt_vld_p1 && bus.evt_ready;

  assign bus.arm_ready = (r_state[bus.arm_slot] == IDLE);
  assign w_arm_hs      = bus.arm_valid && bus.arm_ready;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_req[i] = (r_state[i] == PENDING);
    end
  end

  rr_arbiter #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_req),
    .i_en    (w_load),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_now  <= '0;
      r_step <= STEP_RESET[STEP_W-1:0];
    end else begin
      if (en) begin
        r_now <= r_now + r_step;
      end
      if (cfg_step_we) begin
        r_step <= cfg_step;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_state[i] <= IDLE;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        case (r_state[i])
          IDLE:    if (w_arm_hs && bus.arm_slot == SLOT_W'(i)) r_state[i] <= ARMED;
          ARMED:   if (is_expired(w_now_int, r_target[i]))     r_state[i] <= PENDING;
          PENDING: if (w_load && w_grant[i])                   r_state[i] <= IN_OUT;
          IN_OUT:  if (w_evt_hs && r_evt_slot_p1 == SLOT_W'(i)) r_state[i] <= IDLE;
          default: r_state[i] <= IDLE;
        endcase
      end
    end
  end

  // Targets are pure data qualified by the slot state; no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (r_state[i] == IDLE && w_arm_hs && bus.arm_slot == SLOT_W'(i)) begin
        r_target[i] <= bus.arm_time;
      end
    end
  end

  // ---- stage p1: registered event output ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_vld_p1  <= 1'b0;
      r_evt_slot_p1 <= '0;
      r_evt_time_p1 <= '0;
    end else if (w_load) begin
      r_evt_vld_p1 <= w_any;
      if (w_any) begin
        r_evt_slot_p1 <= w_idx;
        r_evt_time_p1 <= r_target[w_idx];
      end
    end
  end

  assign bus.evt_valid = r_evt_vld_p1;
  assign bus.evt_slot  = r_evt_slot_p1;
  assign bus.evt_time  = r_evt_time_p1;

endmodule

// File: tb/tb_timebase_event_scheduler.sv
// Directed bench for timebase_event_scheduler: reset state, step programming,
// single alarm latency, RR delivery under back-pressure, time wrap, mid-run reset.
module tb_timebase_event_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_step_we;
  logic [39:0] cfg_step;
  logic [39:0] now_time;

  int total = 0;
  int bad   = 0;

  timebase_event_scheduler_if #(.TIME_W(32), .SLOT_W(2)) bus ();

  timebase_event_scheduler #(
    .TIME_W     (32),
    .FRAC_W     (8),
    .NUM_SLOTS  (4),
    .SLOT_W     (2),
    .STEP_RESET (64'h100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_step_we (cfg_step_we),
    .cfg_step    (cfg_step),
    .now_time    (now_time),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm(input logic [1:0] slot, input logic [31:0] t);
    bus.arm_valid = 1'b1;
    bus.arm_slot  = slot;
    bus.arm_time  = t;
    tick();
    bus.arm_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    en            = 1'b0;
    cfg_step_we   = 1'b0;
    cfg_step      = '0;
    bus.arm_valid = 1'b0;
    bus.arm_slot  = '0;
    bus.arm_time  = '0;
    bus.evt_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_now", now_time, 0);
    chk("rst_evt_valid", bus.evt_valid, 0);
    chk("rst_evt_slot", bus.evt_slot, 0);
    chk("rst_evt_time", bus.evt_time, 0);
    for (int s = 0; s < 4; s++) begin
      bus.arm_slot = 2'(s);
      #1;
      chk("rst_arm_ready", bus.arm_ready, 1);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    chk("rst_step", now_time, 40'h100);

    // 2: step 5.52 ns for 100 cycles
    do_reset();
    cfg_step    = 40'h585;
    cfg_step_we = 1'b1;
    tick();
    cfg_step_we = 1'b0;
    en          = 1'b1;
    repeat (100) tick();
    en = 1'b0;
    chk("step_100", now_time, 40'h227F4);

    // 3: single alarm, slot 2 target 10
    do_reset();
    en = 1'b1;
    arm(2'd2, 32'd10);
    repeat (9) tick();
    chk("s3_now10", now_time, 40'hA00);
    chk("s3_arm_ready_busy", bus.arm_ready, 0);
    chk("s3_no_evt_e10", bus.evt_valid, 0);
    tick();
    chk("s3_no_evt_e11", bus.evt_valid, 0);
    tick();
    chk("s3_evt_valid", bus.evt_valid, 1);
    chk("s3_evt_slot", bus.evt_slot, 2);
    chk("s3_evt_time", bus.evt_time, 10);
    tick();
    chk("s3_evt_drained", bus.evt_valid, 0);
    chk("s3_arm_ready_free", bus.arm_ready, 1);

    // 4: three alarms, back-pressure then RR drain
    do_reset();
    en = 1'b1;
    repeat (6) tick();
    en            = 1'b0;
    bus.evt_ready = 1'b0;
    arm(2'd0, 32'd5);
    arm(2'd1, 32'd5);
    arm(2'd3, 32'd5);
    for (int k = 0; k < 3; k++) begin
      chk("s4_hold_valid", bus.evt_valid, 1);
      chk("s4_hold_slot", bus.evt_slot, 0);
      chk("s4_hold_time", bus.evt_time, 5);
      if (k < 2) tick();
    end
    bus.evt_ready = 1'b1;
    tick();
    chk("s4_second_valid", bus.evt_valid, 1);
    chk("s4_second_slot", bus.evt_slot, 1);
    tick();
    chk("s4_third_valid", bus.evt_valid, 1);
    chk("s4_third_slot", bus.evt_slot, 3);
    tick();
    chk("s4_empty", bus.evt_valid, 0);

    // 5: time wrap
    do_reset();
    cfg_step    = 40'hFF_FFFF_FE00;
    cfg_step_we = 1'b1;
    tick();
    cfg_step_we = 1'b0;
    en          = 1'b1;
    tick();
    en          = 1'b0;
    cfg_step    = 40'h100;
    cfg_step_we = 1'b1;
    tick();
    cfg_step_we = 1'b0;
    chk("s5_now_pre", now_time, 40'hFF_FFFF_FE00);
    arm(2'd1, 32'hFFFF_FFF0);
    chk("s5_a1_no_evt", bus.evt_valid, 0);
    arm(2'd0, 32'd2);
    chk("s5_a2_no_evt", bus.evt_valid, 0);
    tick();
    chk("s5_past_valid", bus.evt_valid, 1);
    chk("s5_past_slot", bus.evt_slot, 1);
    chk("s5_past_time", bus.evt_time, 32'hFFFF_FFF0);
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("s5_wait_no_evt", bus.evt_valid, 0);
      if (k == 4) chk("s5_now_wrapped", now_time, 40'h200);
    end
    tick();
    en = 1'b0;
    chk("s5_wrap_valid", bus.evt_valid, 1);
    chk("s5_wrap_slot", bus.evt_slot, 0);
    chk("s5_wrap_time", bus.evt_time, 2);

    // 6: reset while slot 1 pending and an event is presented
    do_reset();
    en = 1'b1;
    repeat (6) tick();
    en            = 1'b0;
    bus.evt_ready = 1'b0;
    arm(2'd0, 32'd5);
    arm(2'd1, 32'd5);
    tick();
    chk("s6_pre_valid", bus.evt_valid, 1);
    bus.arm_slot = 2'd1;
    #1;
    chk("s6_pre_slot1_busy", bus.arm_ready, 0);
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", bus.evt_valid, 0);
    chk("s6_rst_now", now_time, 0);
    for (int s = 0; s < 4; s++) begin
      bus.arm_slot = 2'(s);
      #0.5;
      chk("s6_rst_arm_ready", bus.arm_ready, 1);
    end
    tick();
    rst           = 1'b0;
    bus.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s6_post_no_evt", bus.evt_valid, 0);
    end
    chk("s6_post_now", now_time, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
